// File: rtl/hilo_div_unit.sv
//------------------------------------------------------------------------------
// Module      : hilo_div_unit
// Description : HI/LO special-register pair with direct writes, optional
//               multiply-accumulate into {HI,LO} and an iterative restoring
//               signed/unsigned divider (quotient -> LO, remainder -> HI).
//               Optional feature macro: HILO_ACC_EN (builds the accumulator).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_hi,
    input  logic                 we_lo,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    input  logic                 acc_en,
    input  logic                 acc_sub,
    input  logic [2*WIDTH-1:0]   mul_prod,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 div_annul,
    output logic                 busy,
    output logic                 div_done,
    output logic [WIDTH-1:0]     hi_o,
    output logic [WIDTH-1:0]     lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
    logic               r_q_neg;
    logic               r_r_neg;

    // Operand magnitudes and signs at start time
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_div_zero;
    logic               w_start;

    assign w_dvd_neg  = div_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = div_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_start    = div_start & ~div_annul;

    // One restoring step: the trial subtraction's borrow bit decides the quotient bit.
    // {rem,bit} < 2*divisor, so the W+1 bit difference never overflows.
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_last;

    assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign w_ge      = ~w_trial[WIDTH];
    assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_fix = r_q_neg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fix = r_r_neg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Accumulator path; without the feature the inputs are deliberately left dangling
    logic               w_acc_do;
    logic [2*WIDTH-1:0] w_acc_sum;
`ifdef HILO_ACC_EN
    assign w_acc_do  = acc_en;
    assign w_acc_sum = acc_sub ? ({r_hi, r_lo} - mul_prod) : ({r_hi, r_lo} + mul_prod);
`else
    logic               w_acc_unused;
    assign w_acc_do     = 1'b0;
    assign w_acc_sum    = {r_hi, r_lo};
    assign w_acc_unused = ^{acc_en, acc_sub, mul_prod};
`endif

    // Divider control: next state and the result-write strobe
    logic               w_res_we;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Next-state and result selection
    always_comb begin
        w_state_nxt = r_state;
        w_res_we    = 1'b0;
        w_res_hi    = w_rem_fix;
        w_res_lo    = w_quo_fix;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_div_zero) begin
                        w_state_nxt = S_DONE;
                        w_res_we    = 1'b1;
                        w_res_hi    = dividend;
                        w_res_lo    = '1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (div_annul) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_res_we    = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Divider datapath: capture operands on start, iterate while running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (r_state == S_IDLE && w_start) begin
            r_cnt   <= '0;
            r_quo   <= w_dvd_mag;
            r_rem   <= '0;
            r_dvs   <= w_dvs_mag;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
        end else if (r_state == S_RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // HI/LO update: divide result, then per-half direct writes, then accumulate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_res_we) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state != S_RUN) begin
            if (we_hi || we_lo) begin
                if (we_hi) r_hi <= hi_i;
                if (we_lo) r_lo <= lo_i;
            end else if (w_acc_do) begin
                {r_hi, r_lo} <= w_acc_sum;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign div_done = (r_state == S_DONE);
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_hilo_div_unit
// Description : Self-checking bench for hilo_div_unit (WIDTH=32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hilo_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           we_hi, we_lo;
    logic [W-1:0]   hi_i, lo_i;
    logic           acc_en, acc_sub;
    logic [2*W-1:0] mul_prod;
    logic           div_start, div_signed, div_annul;
    logic [W-1:0]   dividend, divisor;
    logic           busy, div_done;
    logic [W-1:0]   hi_o, lo_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .we_hi      (we_hi),
        .we_lo      (we_lo),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .acc_en     (acc_en),
        .acc_sub    (acc_sub),
        .mul_prod   (mul_prod),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_annul  (div_annul),
        .busy       (busy),
        .div_done   (div_done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        we_hi = 0; we_lo = 0; hi_i = '0; lo_i = '0;
        acc_en = 0; acc_sub = 0; mul_prod = '0;
        div_start = 0; div_signed = 0; div_annul = 0;
        dividend = '0; divisor = '0;
    endtask

    // Reference divide from plain arithmetic; 64-bit signed math makes MIN/-1 wrap naturally
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Start a divide and wait (bounded) for div_done; reports latency and whether busy stayed high
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output int lat, output logic busy_ok);
        dividend = a; divisor = b; div_signed = s; div_start = 1;
        tick();
        div_start = 0;
        lat = 1;
        busy_ok = 1;
        while (!div_done && lat < 200) begin
            if (!busy) busy_ok = 0;
            tick();
            lat++;
        end
    endtask

    int           lat;
    logic         bok;
    logic [W-1:0] eq, er, h0, l0;
    logic [2*W-1:0] m;
    int           seen;

    initial begin
        vt[0] = '{a: 32'd100,        b: 32'd7,          s: 1'b0, q: 32'd14,         r: 32'd2};
        vt[1] = '{a: 32'hFFFFFFF9,   b: 32'd2,          s: 1'b1, q: 32'hFFFFFFFD,   r: 32'hFFFFFFFF};
        vt[2] = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   s: 1'b1, q: 32'h80000000,   r: 32'h0};
        vt[3] = '{a: 32'h55,         b: 32'h0,          s: 1'b0, q: 32'hFFFFFFFF,   r: 32'h55};
        vt[4] = '{a: 32'hFFFFFFF9,   b: 32'h0,          s: 1'b1, q: 32'hFFFFFFFF,   r: 32'hFFFFFFF9};
        vt[5] = '{a: 32'hFFFFFFFF,   b: 32'd1,          s: 1'b0, q: 32'hFFFFFFFF,   r: 32'h0};
        vt[6] = '{a: 32'd7,          b: 32'hFFFFFFFF,   s: 1'b0, q: 32'h0,          r: 32'd7};
        vt[7] = '{a: 32'hFFFFFFF9,   b: 32'hFFFFFFFE,   s: 1'b1, q: 32'd3,          r: 32'hFFFFFFFF};
        vt[8] = '{a: 32'd7,          b: 32'hFFFFFFFE,   s: 1'b1, q: 32'hFFFFFFFD,   r: 32'd1};

        clear_in();
        rst = 0;
        repeat (3) tick();
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", div_done, 0);
        rst = 1;
        tick();

        // Independent half writes
        we_hi = 1; hi_i = 32'h12345678;
        tick();
        we_hi = 0;
        chk("wr_hi", hi_o, 32'h12345678);
        chk("wr_hi_lo_kept", lo_o, 0);
        we_lo = 1; lo_i = 32'hCAFEF00D;
        tick();
        we_lo = 0;
        chk("wr_lo_hi_kept", hi_o, 32'h12345678);
        chk("wr_lo", lo_o, 32'hCAFEF00D);

        // 100/7 with writes and accumulates attempted during busy
        dividend = 32'd100; divisor = 32'd7; div_signed = 0; div_start = 1;
        tick();
        div_start = 0;
        lat = 1; bok = 1;
        while (!div_done && lat < 200) begin
            if (!busy) bok = 0;
            we_lo = lat[0]; we_hi = lat[1]; lo_i = 32'hDEADBEEF; hi_i = 32'hBADC0DE5;
            acc_en = 1; mul_prod = 64'd5;
            tick();
            lat++;
        end
        clear_in();
        chk("u100_7_lat", 64'(lat), 64'(W + 1));
        chk("u100_7_busy", bok, 1);
        chk("u100_7_lo", lo_o, 14);
        chk("u100_7_hi", hi_o, 2);
        tick();
        chk("u100_7_done_pulse", div_done, 0);

        // Table of directed divides
        for (int i = 0; i < 9; i++) begin
            run_div(vt[i].a, vt[i].b, vt[i].s, lat, bok);
            chk($sformatf("vec%0d_lat", i), 64'(lat), (vt[i].b == '0) ? 64'd1 : 64'(W + 1));
            chk($sformatf("vec%0d_busy", i), bok, 1);
            chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
            chk($sformatf("vec%0d_lo", i), lo_o, vt[i].q);
            chk($sformatf("vec%0d_hi", i), hi_o, vt[i].r);
            if (i == 0) begin
                // start while in DONE must be ignored
                dividend = 32'd9; divisor = 32'd0; div_start = 1;
            end
            tick();
            div_start = 0;
            chk($sformatf("vec%0d_done_pulse", i), div_done, 0);
            if (i == 0) begin
                chk("start_in_done_busy", busy, 0);
                chk("start_in_done_lo", lo_o, vt[0].q);
                chk("start_in_done_hi", hi_o, vt[0].r);
            end
        end

        // Annul at RUN cycle 10
        h0 = hi_o; l0 = lo_o;
        dividend = 32'd1000; divisor = 32'd3; div_signed = 0; div_start = 1;
        tick();
        div_start = 0;
        repeat (9) tick();
        chk("annul_busy_before", busy, 1);
        div_annul = 1;
        tick();
        div_annul = 0;
        chk("annul_busy", busy, 0);
        chk("annul_done", div_done, 0);
        seen = 0;
        repeat (40) begin
            if (div_done || busy) seen++;
            tick();
        end
        chk("annul_no_done", 64'(seen), 0);
        chk("annul_hi", hi_o, h0);
        chk("annul_lo", lo_o, l0);
        run_div(32'd1000, 32'd3, 1'b0, lat, bok);
        chk("after_annul_lat", 64'(lat), 64'(W + 1));
        chk("after_annul_lo", lo_o, 333);
        chk("after_annul_hi", hi_o, 1);
        tick();

        // Annul together with start in IDLE: nothing starts, no write
        div_annul = 1; div_start = 1; dividend = 32'h77; divisor = 32'h0;
        tick();
        clear_in();
        chk("annul_start_busy", busy, 0);
        chk("annul_start_done", div_done, 0);
        chk("annul_start_hi", hi_o, 1);
        chk("annul_start_lo", lo_o, 333);

        // Accumulate
        we_hi = 1; hi_i = 32'h0; we_lo = 1; lo_i = 32'hFFFFFFFF;
        tick();
        clear_in();
        acc_en = 1; acc_sub = 0; mul_prod = 64'd1;
        tick();
`ifdef HILO_ACC_EN
        chk("madd_hi", hi_o, 1);
        chk("madd_lo", lo_o, 0);
`else
        chk("madd_off_hi", hi_o, 0);
        chk("madd_off_lo", lo_o, 32'hFFFFFFFF);
`endif
        acc_sub = 1; mul_prod = 64'd2;
        tick();
`ifdef HILO_ACC_EN
        chk("msub_hi", hi_o, 0);
        chk("msub_lo", lo_o, 32'hFFFFFFFE);
`else
        chk("msub_off_hi", hi_o, 0);
        chk("msub_off_lo", lo_o, 32'hFFFFFFFF);
`endif
        h0 = hi_o;
        acc_sub = 0; mul_prod = 64'h100000000; we_lo = 1; lo_i = 32'h11;
        tick();
        clear_in();
        chk("acc_vs_we_hi", hi_o, h0);
        chk("acc_vs_we_lo", lo_o, 32'h11);

        // Random accumulates against a 64-bit running model
        m = {hi_o, lo_o};
        for (int i = 0; i < 10; i++) begin
            acc_en = 1;
            acc_sub = 1'($urandom_range(0, 1));
            mul_prod = {32'($urandom), 32'($urandom)};
`ifdef HILO_ACC_EN
            m = acc_sub ? (m - mul_prod) : (m + mul_prod);
`endif
            tick();
            chk($sformatf("racc%0d", i), {hi_o, lo_o}, m);
        end
        clear_in();

        // Random divides against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = 32'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er);
            run_div(a, b, s, lat, bok);
            chk($sformatf("rdiv%0d_lat", i), 64'(lat), (b == '0) ? 64'd1 : 64'(W + 1));
            chk($sformatf("rdiv%0d_q", i), lo_o, eq);
            chk($sformatf("rdiv%0d_r", i), hi_o, er);
            if (!bok) chk($sformatf("rdiv%0d_busy", i), bok, 1);
            tick();
        end

        // Asynchronous reset in the middle of a divide
        run_div(32'd1000, 32'd3, 1'b0, lat, bok);
        tick();
        dividend = 32'd5000; divisor = 32'd9; div_start = 1;
        tick();
        div_start = 0;
        repeat (5) tick();
        rst = 0;
        #1;
        chk("async_rst_hi", hi_o, 0);
        chk("async_rst_lo", lo_o, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", div_done, 0);
        tick();
        rst = 1;
        repeat (40) tick();
        chk("post_rst_hi", hi_o, 0);
        chk("post_rst_lo", lo_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Parametrised successor to the HI/LO special-register pair in the execute stage.
- Holds HI/LO and supports:
  - independent HI and LO writes;
  - multiply-accumulate into {HI,LO};
  - an in-block iterative signed/unsigned divider that writes quotient to LO and remainder to HI.
- Drives a busy signal so the pipeline stalls while a divide is in progress.

Parameters:
- WIDTH, 32, width of each of HI and LO; the divider operand width. Must be at least 2.
- CNT_W, 6, width of the divide iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we_hi  in  1  write hi_i into HI.
- we_lo  in  1  write lo_i into LO.
- hi_i  in  WIDTH  HI write data.
- lo_i  in  WIDTH  LO write data.
- acc_en  in  1  accumulate mul_prod into {HI,LO}.
- acc_sub  in  1  0 = add (MADD), 1 = subtract (MSUB).
- mul_prod  in  2*WIDTH  product from the multiplier.
- div_start  in  1  start a divide; sampled only in IDLE.
- div_signed  in  1  1 = signed divide, 0 = unsigned.
- dividend  in  WIDTH  dividend; captured on start.
- divisor  in  WIDTH  divisor; captured on start.
- div_annul  in  1  cancel an in-flight divide (pipeline flush).
- busy  out  1  high in RUN.
- div_done  out  1  one-cycle pulse; results are already in HI/LO.
- hi_o  out  WIDTH  registered HI.
- lo_o  out  WIDTH  registered LO.

Behaviour:
- Reset:
  - rst low asynchronously clears hi_o, lo_o, busy, div_done and all divider state.
  - State goes to IDLE.
  - Reset mid-divide aborts the divide with no write.
- States: IDLE, RUN, DONE.
- IDLE:
  - div_start=1 captures the magnitudes of the operands; in signed mode the magnitudes are the absolute values.
  - It also records the quotient sign (sign(dividend) xor sign(divisor)) and the remainder sign (sign(dividend)).
- IDLE transitions on div_start:
  - Divisor zero: go directly to DONE. Write HI=dividend and LO=all ones at that same edge.
  - Otherwise: go to RUN with counter=0.
- RUN:
  - Restoring radix-2 division, one quotient bit per cycle, for exactly WIDTH cycles.
  - On the edge that completes iteration WIDTH-1, apply the sign fixups and write LO=quotient and HI=remainder. State goes to DONE.
  - Net latency: start at edge E0 gives results visible after edge E0+WIDTH, with div_done high in the following cycle.
- DONE:
  - div_done=1 for exactly one cycle, then return to IDLE.
  - A div_start in DONE is ignored.
- div_annul:
  - In RUN: go to IDLE at the next edge with no HI/LO write and no div_done. div_annul is ignored in IDLE and DONE.
  - div_annul and div_start together in IDLE: no divide starts.
- Signed overflow: most-negative / -1 gives LO=most-negative and HI=0 (modulo wrap).
- Update priority when not in RUN (highest first):
  1. divider result write;
  2. we_hi/we_lo, applied per half, so one half may be written while the other keeps its value;
  3. acc_en.
- Accumulate: {HI,LO} <= {HI,LO} ± mul_prod, modulo 2^(2*WIDTH).
- acc_en combined with any of we_hi/we_lo in the same cycle: the direct writes win and the accumulate is dropped.
- In RUN: we_hi, we_lo and acc_en are ignored; the pipeline is required to stall on busy.
- Outputs are registered. A write is visible on hi_o/lo_o the cycle after the write edge; there is no combinational bypass.

Optional Feature:
- Macro: HILO_ACC_EN.
- Defined: acc_en, acc_sub and mul_prod behave as above; the 2*WIDTH adder/subtractor is built.
- Undefined:
  - acc_en, acc_sub and mul_prod are ignored and no adder is synthesised.
  - Ports remain present.
  - {HI,LO} changes only through direct writes or divide results.

Test Plan:
- Reset/write:
  - Assert rst=0 mid-operation -> hi_o=lo_o=0, busy=0, div_done=0 immediately.
  - Release, then we_hi=1 with hi_i=0x12345678 -> hi_o=0x12345678, lo_o stays 0.
- Unsigned divide (WIDTH=32): dividend=100, divisor=7, div_signed=0, start at edge E0 ->
  - busy=1 during cycles 1..32;
  - after edge E0+32, lo_o=14, hi_o=2;
  - div_done pulses one cycle;
  - we_lo pulses during busy are ignored.
- Signed divide: dividend=-7 (0xFFFFFFF9), divisor=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Divide by zero: dividend=0x55, divisor=0 -> next cycle hi_o=0x55, lo_o=0xFFFFFFFF, div_done=1, busy never set.
- Annul and accumulate:
  - div_annul at cycle 10 of RUN -> HI/LO unchanged, no div_done, back in IDLE; a new start then completes normally.
  - With HILO_ACC_EN, {HI,LO}={0,0xFFFFFFFF}, acc_en=1, mul_prod=1 -> hi_o=1, lo_o=0.
  - Then acc_sub=1, mul_prod=2 -> hi_o=0, lo_o=0xFFFFFFFE.
